// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory port arbiter.
package mem_arbiter_pkg;

  // Transaction phase of the shared memory port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Which requester currently owns the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  // All byte lanes; reads implicitly use the full word
  localparam logic [7:0] MASK_ALL = 8'hFF;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetch unit (read-only)
// and the load/store unit. LSU wins ties, but after MAX_STREAK consecutive
// LSU grants with the IFU waiting, the IFU is served. A response timeout
// hands the owner an error and then drains the late memory response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);
  localparam logic [7:0] TCNT_LIMIT   = 8'(TIMEOUT);

  state_t     state, state_next;
  owner_t     owner, owner_next;
  logic [3:0] streak, streak_next;
  logic [7:0] tcnt, tcnt_next;
  logic       own_resp_ready;
  logic       timed_out;
  logic       grant_lsu;
  logic       grant_ifu;

  assign own_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready :
                          (owner == OWN_IFU) ? ifu_resp_ready : 1'b0;

  assign timed_out = (TIMEOUT != 0) && (state == RESP) && (tcnt == TCNT_LIMIT);

  // Fixed LSU-first priority, overridden once the IFU has waited through a full streak
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (lsu_req_valid && !(ifu_req_valid && (streak == STREAK_LIMIT))) begin
      grant_lsu = 1'b1;
    end else if (ifu_req_valid) begin
      grant_ifu = 1'b1;
    end
  end

  // State, owner, streak and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= OWN_NONE;
      streak <= '0;
      tcnt   <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      streak <= streak_next;
      tcnt   <= tcnt_next;
    end
  end

  // Next-state logic: grant in IDLE, then walk one transaction through REQ/RESP
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    streak_next = streak;
    tcnt_next   = tcnt;
    case (state)
      IDLE: begin
        owner_next = OWN_NONE;
        if (grant_lsu) begin
          owner_next = OWN_LSU;
          state_next = REQ;
          if (!ifu_req_valid) begin
            streak_next = '0;
          end else if (streak != STREAK_LIMIT) begin
            streak_next = streak + 4'd1;
          end
        end else if (grant_ifu) begin
          owner_next  = OWN_IFU;
          state_next  = REQ;
          streak_next = '0;
        end else begin
          streak_next = '0;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_next = RESP;
          tcnt_next  = '0;
        end
      end
      RESP: begin
        if (timed_out) begin
          if (own_resp_ready) begin
            state_next = DRAIN;
            owner_next = OWN_NONE;
          end
        end else if (mem_resp_valid && own_resp_ready) begin
          state_next = IDLE;
          owner_next = OWN_NONE;
        end else if (tcnt != 8'hFF) begin
          tcnt_next = tcnt + 8'd1;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_next = IDLE;
          owner_next = OWN_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output steering: only the owner sees handshakes, everything else idles at zero
  always_comb begin
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = 8'h00;
    mem_resp_ready = 1'b0;
    case (state)
      REQ: begin
        if (owner == OWN_LSU) begin
          mem_req_valid = 1'b1;
          mem_addr      = lsu_addr;
          mem_wen       = lsu_wen;
          mem_wdata     = lsu_wdata;
          mem_wmask     = lsu_wmask;
          lsu_req_ready = mem_req_ready;
        end else if (owner == OWN_IFU) begin
          mem_req_valid = 1'b1;
          mem_addr      = ifu_addr;
          mem_wmask     = ~MASK_ALL;
          ifu_req_ready = mem_req_ready;
        end
      end
      RESP: begin
        if (timed_out) begin
          ifu_resp_valid = (owner == OWN_IFU);
          ifu_resp_err   = (owner == OWN_IFU);
          lsu_resp_valid = (owner == OWN_LSU);
          lsu_resp_err   = (owner == OWN_LSU);
        end else begin
          mem_resp_ready = own_resp_ready;
          if (owner == OWN_LSU) begin
            lsu_resp_valid = mem_resp_valid;
            lsu_rdata      = mem_rdata;
          end else if (owner == OWN_IFU) begin
            ifu_resp_valid = mem_resp_valid;
            ifu_rdata      = mem_rdata;
          end
        end
      end
      DRAIN: begin
        mem_resp_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and a memory model run in one
// per-cycle process; expected memory requests and responses are queued when
// stimulus is issued and checked as the handshakes occur.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } memReq_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] ifuCmdQ[$];
  memReq_t     lsuCmdQ[$];
  memReq_t     memReqQ[$];
  resp_t       ifuRespQ[$];
  resp_t       lsuRespQ[$];

  int          cycle = 0;
  int          respDelay = 0;
  logic        ifuRespReadyVal = 1'b1;
  logic        lsuRespReadyVal = 1'b1;
  logic        ifuPresented = 1'b0;
  logic        lsuPresented = 1'b0;
  int          ifuStart = 0;
  int          lsuStart = 0;
  logic        memPending = 1'b0;
  int          memDelay = 0;
  logic [31:0] memPendData = '0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something blocks outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] memData(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 32'h0000_0413;
    return addr ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctrl"}, 64'({ifu_req_ready, ifu_resp_valid, ifu_resp_err, lsu_req_ready,
                                    lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen,
                                    mem_resp_ready}), 64'd0);
    checkOutput({tag, "IfuRdata"}, 64'(ifu_rdata), 64'd0);
    checkOutput({tag, "LsuRdata"}, 64'(lsu_rdata), 64'd0);
    checkOutput({tag, "MemAddr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, "MemWdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, "MemWmask"}, 64'(mem_wmask), 64'd0);
  endtask

  // Queue one request plus its expected memory-side request and response
  task automatic applyStimulus(input logic isLsu, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [7:0] wmask,
                               input logic expErr, input int expLat);
    memReq_t mr;
    resp_t   rs;
    mr.addr  = addr;
    mr.wen   = isLsu ? wen : 1'b0;
    mr.wdata = isLsu ? wdata : 32'd0;
    mr.wmask = isLsu ? wmask : 8'h00;
    memReqQ.push_back(mr);
    rs.data = (expErr || mr.wen) ? 32'd0 : memData(addr);
    rs.err  = expErr;
    rs.lat  = expLat;
    if (isLsu) begin
      lsuCmdQ.push_back(mr);
      lsuRespQ.push_back(rs);
    end else begin
      ifuCmdQ.push_back(addr);
      ifuRespQ.push_back(rs);
    end
  endtask

  function automatic int outstanding();
    return ifuCmdQ.size() + lsuCmdQ.size() + memReqQ.size() + ifuRespQ.size()
         + lsuRespQ.size() + (memPending ? 1 : 0);
  endfunction

  task automatic waitDone(input string tag, input int maxCycles);
    int n = 0;
    while (outstanding() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "Pending"}, 64'(outstanding()), 64'd0);
    @(posedge clk);
  endtask

  task automatic sampleCycle();
    memReq_t exp;
    resp_t   rs;
    checkOutput("exclusive", 64'({ifu_req_ready & lsu_req_ready, ifu_resp_valid & lsu_resp_valid}), 64'd0);
    if (ifu_resp_valid && !ifu_resp_ready) checkOutput("ifuRespHold", 64'(mem_resp_ready), 64'd0);
    if (lsu_resp_valid && !lsu_resp_ready) checkOutput("lsuRespHold", 64'(mem_resp_ready), 64'd0);
    if (mem_req_valid && mem_req_ready) begin
      checkOutput("memReqExpected", 64'(memReqQ.size() != 0), 64'd1);
      if (memReqQ.size() != 0) begin
        exp = memReqQ.pop_front();
        checkOutput("memAddr", 64'(mem_addr), 64'(exp.addr));
        checkOutput("memWen", 64'(mem_wen), 64'(exp.wen));
        checkOutput("memWdata", 64'(mem_wdata), 64'(exp.wdata));
        checkOutput("memWmask", 64'(mem_wmask), 64'(exp.wmask));
      end
      memPending  = 1'b1;
      memDelay    = respDelay;
      memPendData = mem_wen ? 32'd0 : memData(mem_addr);
    end
    if (mem_resp_valid && mem_resp_ready) memPending = 1'b0;
    if (ifu_req_valid && ifu_req_ready) begin
      void'(ifuCmdQ.pop_front());
      ifuPresented = 1'b0;
    end
    if (lsu_req_valid && lsu_req_ready) begin
      void'(lsuCmdQ.pop_front());
      lsuPresented = 1'b0;
    end
    if (ifu_resp_valid && ifu_resp_ready) begin
      checkOutput("ifuRespExpected", 64'(ifuRespQ.size() != 0), 64'd1);
      if (ifuRespQ.size() != 0) begin
        rs = ifuRespQ.pop_front();
        checkOutput("ifuRdata", 64'(ifu_rdata), 64'(rs.data));
        checkOutput("ifuErr", 64'(ifu_resp_err), 64'(rs.err));
        if (rs.lat >= 0) checkOutput("ifuLatency", 64'(cycle - ifuStart), 64'(rs.lat));
      end
    end
    if (lsu_resp_valid && lsu_resp_ready) begin
      checkOutput("lsuRespExpected", 64'(lsuRespQ.size() != 0), 64'd1);
      if (lsuRespQ.size() != 0) begin
        rs = lsuRespQ.pop_front();
        checkOutput("lsuRdata", 64'(lsu_rdata), 64'(rs.data));
        checkOutput("lsuErr", 64'(lsu_resp_err), 64'(rs.err));
        if (rs.lat >= 0) checkOutput("lsuLatency", 64'(cycle - lsuStart), 64'(rs.lat));
      end
    end
  endtask

  // Requesters and memory model: drive on the falling edge, sample just before the rising edge
  initial begin
    ifu_req_valid = 1'b0; ifu_addr = '0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (ifuCmdQ.size() != 0) begin
        if (!ifuPresented) begin
          ifuStart     = cycle;
          ifuPresented = 1'b1;
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = ifuCmdQ[0];
      end else begin
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
      end
      if (lsuCmdQ.size() != 0) begin
        if (!lsuPresented) begin
          lsuStart     = cycle;
          lsuPresented = 1'b1;
        end
        lsu_req_valid = 1'b1;
        lsu_addr      = lsuCmdQ[0].addr;
        lsu_wen       = lsuCmdQ[0].wen;
        lsu_wdata     = lsuCmdQ[0].wdata;
        lsu_wmask     = lsuCmdQ[0].wmask;
      end else begin
        lsu_req_valid = 1'b0;
        lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      end
      ifu_resp_ready = ifuRespReadyVal;
      lsu_resp_ready = lsuRespReadyVal;
      if (!rst_n) memPending = 1'b0;
      if (memPending && memDelay == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = memPendData;
      end else begin
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        if (memPending && memDelay > 0) memDelay--;
      end
      mem_req_ready = 1'b1;
      #4;
      if (rst_n) sampleCycle();
    end
  end

  // Directed scenarios
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);

    $display("[TB] IFU-only read, zero-wait memory");
    applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'd0, 8'h00, 1'b0, 2);
    waitDone("ifuOnly", 40);

    $display("[TB] Simultaneous LSU write and IFU read");
    applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 1'b0, -1);
    applyStimulus(1'b0, 32'h8000_0004, 1'b0, 32'd0, 8'h00, 1'b0, -1);
    waitDone("both", 40);

    $display("[TB] LSU streak against waiting IFU");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h8000_2000 + 32'(4 * i), 1'b0, 32'd0, 8'hFF, 1'b0, -1);
    applyStimulus(1'b0, 32'h8000_0100, 1'b0, 32'd0, 8'h00, 1'b0, -1);
    for (int i = 4; i < 8; i++)
      applyStimulus(1'b1, 32'h8000_2000 + 32'(4 * i), 1'b0, 32'd0, 8'hFF, 1'b0, -1);
    applyStimulus(1'b0, 32'h8000_0104, 1'b0, 32'd0, 8'h00, 1'b0, -1);
    waitDone("streak", 200);

    $display("[TB] Response timeout with late memory response");
    respDelay = 12;
    applyStimulus(1'b0, 32'h8000_0200, 1'b0, 32'd0, 8'h00, 1'b1, 10);
    waitDone("timeout", 60);
    respDelay = 0;

    $display("[TB] LSU response back-pressure");
    lsuRespReadyVal = 1'b0;
    applyStimulus(1'b1, 32'h8000_0300, 1'b0, 32'd0, 8'hFF, 1'b0, 7);
    repeat (7) @(posedge clk);
    lsuRespReadyVal = 1'b1;
    waitDone("stall", 40);

    $display("[TB] Asynchronous reset in RESP");
    respDelay = 5;
    applyStimulus(1'b1, 32'h8000_0400, 1'b0, 32'd0, 8'hFF, 1'b0, -1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("midReset");
    lsuRespQ.delete();
    memReqQ.delete();
    lsuCmdQ.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    respDelay = 0;
    @(posedge clk);
    applyStimulus(1'b0, 32'h8000_0500, 1'b0, 32'd0, 8'h00, 1'b0, 2);
    waitDone("afterReset", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory block. It replaces the direct combinational memory hookup once the core moves to multi-cycle handshaked fetch and load/store.
- Arbitration is fixed-priority LSU-first, with an anti-starvation counter for the IFU.
- A response timeout returns an error to the owning requester so that a hung memory cannot hang the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_STREAK, 4, max consecutive LSU grants while the IFU waits; 1..15
TIMEOUT, 255, max cycles in RESP before an error response; 0 disables; max 255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU request valid
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU read address
ifu_resp_valid  out  1  IFU response valid
ifu_resp_ready  in  1  IFU can take response
ifu_rdata  out  DATA_W  IFU read data
ifu_resp_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  8  LSU byte mask
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU can take response
lsu_rdata  out  DATA_W  LSU read data
lsu_resp_err  out  1  LSU response is a timeout error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  forwarded address
mem_wen  out  1  forwarded write enable (IFU: 0)
mem_wdata  out  DATA_W  forwarded write data (IFU: 0)
mem_wmask  out  8  forwarded mask (IFU: 8'h00 for write mask; read mask 8'hFF is implied)
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  arbiter takes response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low. While in reset, state = IDLE, owner = none, streak = 0, tcnt = 0.
- Outputs are combinational from registered state/owner. Every valid/ready/err output is 0 and every data/addr output is 0 when not driven by an active phase (including reset).
- States:
  - IDLE: registers the owner.
  - REQ: forwards the owner's request.
  - RESP: forwards the memory response to the owner.
  - DRAIN: absorbs a late memory response after a timeout.
- IDLE, grant rule:
  - LSU only valid → LSU.
  - IFU only valid → IFU.
  - Both valid → LSU, unless streak == MAX_STREAK, then IFU.
  - Next state is REQ. No ready is asserted in IDLE.
- Streak counter:
  - +1 on an LSU grant while ifu_req_valid = 1.
  - Cleared on an IFU grant, or in IDLE when ifu_req_valid = 0.
  - Saturates at MAX_STREAK.
- REQ:
  - mem_req_valid = 1; mem_addr/wen/wdata/wmask are muxed from the owner.
  - owner req_ready = mem_req_ready.
  - On mem_req_valid & mem_req_ready → RESP, with tcnt cleared.
  - Requesters must hold request fields stable until accepted. A requester dropping req_valid in REQ is a protocol violation and is not handled.
- RESP:
  - owner resp_valid = mem_resp_valid; owner rdata = mem_rdata; mem_resp_ready = owner resp_ready.
  - On handshake → IDLE.
  - tcnt +1 per cycle without a handshake.
  - If TIMEOUT != 0 and tcnt == TIMEOUT: owner resp_valid = 1, resp_err = 1, rdata = 0, and mem_* response signals are not forwarded that cycle.
    - Owner resp_ready = 1 → DRAIN.
    - Otherwise the error response is held, per valid/ready rules.
- DRAIN: mem_resp_ready = 1, no owner outputs. On mem_resp_valid → IDLE.
- Throughput: minimum 3 cycles per transaction with a zero-wait memory (IDLE, REQ, RESP). There is no back-to-back pipelining and only one outstanding transaction.
- The non-owner sees req_ready = 0 and resp_valid = 0 at all times.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DRAIN = 2'd3);
  - the owner encoding (OWN_NONE, OWN_IFU, OWN_LSU);
  - the mask constant 8'hFF.
- No sub-module. The grant logic plus the streak counter is small enough to stay inline.

Test Plan:
- IFU-only read at 0x8000_0000, memory ready immediately, rdata 0x0000_0413 → IFU receives 0x0000_0413, err = 0, on the 3rd cycle after req_valid; mem_wen = 0.
- Both valid in the same cycle, LSU write addr 0x8000_1000, wdata 0xDEADBEEF, wmask 0x0F → LSU is forwarded first with exact fields; IFU is served next.
- LSU requesting continuously while the IFU waits, MAX_STREAK = 4 → exactly 4 LSU grants, then 1 IFU grant, then streak = 0.
- Memory never asserts resp_valid, TIMEOUT = 8 → owner gets resp_err = 1, rdata = 0, 8 cycles after REQ acceptance. A late mem_resp_valid is absorbed in DRAIN and not seen by either requester.
- Owner resp_ready held low for 5 cycles during RESP → mem_resp_ready stays 0 and the response is delivered intact when ready rises.
- rst_n asserted low mid-RESP → all outputs 0 immediately (asynchronously). After release the next request is served normally.
